// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl - serialises input words MSB first and detects a
// configurable bit pattern in the resulting stream.
//
// Ports
//   clk_c, reset_r          clock, asynchronous active-low reset
//   cfg_we_i                config write strobe (honoured in IDLE only)
//   cfg_pattern_i           pattern; bit 0 is compared with the newest bit
//   cfg_len_i               pattern length minus 1
//   cfg_overlap_i           1 = overlapping matches, 0 = non-overlapping
//   cfg_thresh_i            match count that raises irq_o (0 disables)
//   start_i, stop_i         session control strobes
//   irq_clr_i               clears the sticky irq
//   data_valid_i, data_i,
//   data_ready_o            word input handshake (ready only in WAIT)
//   bit_o, bit_valid_o      serialised bit stream
//   match_o                 one-cycle pulse after a completing bit
//   match_cnt_o             saturating match counter
//   irq_o                   sticky threshold interrupt
//   busy_o                  session active (WAIT or SHIFT)
module seq_detect_ctrl #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic                     clk_c,
   input  logic                     reset_r,
   input  logic                     cfg_we_i,
   input  logic [PAT_W-1:0]         cfg_pattern_i,
   input  logic [$clog2(PAT_W)-1:0] cfg_len_i,
   input  logic                     cfg_overlap_i,
   input  logic [CNT_W-1:0]         cfg_thresh_i,
   input  logic                     start_i,
   input  logic                     stop_i,
   input  logic                     irq_clr_i,
   input  logic                     data_valid_i,
   input  logic [PAT_W-1:0]         data_i,
   output logic                     data_ready_o,
   output logic                     bit_o,
   output logic                     bit_valid_o,
   output logic                     match_o,
   output logic [CNT_W-1:0]         match_cnt_o,
   output logic                     irq_o,
   output logic                     busy_o
);

   localparam int LEN_W  = $clog2(PAT_W);
   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [PAT_W-1:0]  ONES     = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [LEN_W-1:0]  LAST_IDX = LEN_W'(PAT_W - 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

   typedef enum logic [1:0] {IDLE, WAIT, SHIFT} state_t;

   state_t             state, state_nxt;
   logic [PAT_W-1:0]   pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [CNT_W-1:0]   thresh_q;
   logic [PAT_W-1:0]   shreg;
   logic [PAT_W-1:0]   hist;
   logic [FILL_W-1:0]  fill;
   logic [LEN_W-1:0]   bit_idx;
   logic               stop_q;
   logic               match_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               irq_q;

   logic               transfer;
   logic               last_bit;
   logic [PAT_W-1:0]   hist_upd;
   logic [FILL_W-1:0]  fill_upd;
   logic [FILL_W-1:0]  len_ext;
   logic [PAT_W-1:0]   mask;
   logic               hit;
   logic [CNT_W-1:0]   cnt_upd;

   always_ff @(posedge clk_c or negedge reset_r) begin
      if (!reset_r) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      data_ready_o = 1'b0;
      bit_valid_o  = 1'b0;
      busy_o       = 1'b0;
      bit_o        = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_nxt = WAIT;
         end
         WAIT: begin
            data_ready_o = 1'b1;
            busy_o       = 1'b1;
            // stop takes priority over a same-cycle transfer
            if (stop_i)            state_nxt = IDLE;
            else if (data_valid_i) state_nxt = SHIFT;
         end
         SHIFT: begin
            bit_valid_o = 1'b1;
            busy_o      = 1'b1;
            bit_o       = shreg[PAT_W-1];
            if (last_bit) state_nxt = (stop_q || stop_i) ? IDLE : WAIT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign transfer = (state == WAIT) && data_valid_i && !stop_i;
   assign last_bit = (bit_idx == LAST_IDX);

   // Detection works on the history as it will be after the current bit,
   // so the match decision and the fill count both include this bit.
   always_comb begin
      hist_upd = {hist[PAT_W-2:0], shreg[PAT_W-1]};
      fill_upd = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
      len_ext  = FILL_W'(len_q) + FILL_W'(1);
      mask     = ONES >> (FILL_MAX - len_ext);
      hit      = (state == SHIFT) && (fill_upd >= len_ext) &&
                 (((hist_upd ^ pat_q) & mask) == '0);
      cnt_upd  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_c or negedge reset_r) begin
      if (!reset_r) begin
         pat_q    <= '0;
         len_q    <= '0;
         ovl_q    <= 1'b0;
         thresh_q <= '0;
         shreg    <= '0;
         hist     <= '0;
         fill     <= '0;
         bit_idx  <= '0;
         stop_q   <= 1'b0;
         match_q  <= 1'b0;
         cnt_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         match_q <= hit;
         if (state == IDLE && cfg_we_i) begin
            pat_q    <= cfg_pattern_i;
            len_q    <= cfg_len_i;
            ovl_q    <= cfg_overlap_i;
            thresh_q <= cfg_thresh_i;
         end
         if (state == IDLE && start_i) begin
            hist  <= '0;
            fill  <= '0;
            cnt_q <= '0;
            irq_q <= 1'b0;
         end else begin
            if (hit) cnt_q <= cnt_upd;
            // a new threshold crossing beats a coincident clear
            if (hit && thresh_q != '0 && cnt_upd == thresh_q) irq_q <= 1'b1;
            else if (irq_clr_i)                               irq_q <= 1'b0;
         end
         if (transfer) begin
            shreg   <= data_i;
            bit_idx <= '0;
            stop_q  <= 1'b0;
         end
         if (state == SHIFT) begin
            shreg <= shreg << 1;
            hist  <= hist_upd;
            fill  <= (hit && !ovl_q) ? '0 : fill_upd;
            if (last_bit) begin
               bit_idx <= '0;
               stop_q  <= 1'b0;
            end else begin
               bit_idx <= bit_idx + LEN_W'(1);
               if (stop_i) stop_q <= 1'b1;
            end
         end
      end
   end

   assign match_o     = match_q;
   assign match_cnt_o = cnt_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: directed session sequence, with a
// reference model that pushes expected bit/match/irq records to a
// scoreboard which a negedge monitor pops as the DUT emits bits.
module tb_seq_detect_ctrl;

   logic       clk_c = 1'b0;
   logic       reset_r;
   logic       cfg_we_i = 1'b0;
   logic [7:0] cfg_pattern_i = '0;
   logic [2:0] cfg_len_i = '0;
   logic       cfg_overlap_i = 1'b0;
   logic [7:0] cfg_thresh_i = '0;
   logic       start_i = 1'b0;
   logic       stop_i = 1'b0;
   logic       irq_clr_i = 1'b0;
   logic       data_valid_i = 1'b0;
   logic [7:0] data_i = '0;
   logic       data_ready_o;
   logic       bit_o;
   logic       bit_valid_o;
   logic       match_o;
   logic [7:0] match_cnt_o;
   logic       irq_o;
   logic       busy_o;

   seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
      .clk_c(clk_c), .reset_r(reset_r), .cfg_we_i(cfg_we_i),
      .cfg_pattern_i(cfg_pattern_i), .cfg_len_i(cfg_len_i),
      .cfg_overlap_i(cfg_overlap_i), .cfg_thresh_i(cfg_thresh_i),
      .start_i(start_i), .stop_i(stop_i), .irq_clr_i(irq_clr_i),
      .data_valid_i(data_valid_i), .data_i(data_i),
      .data_ready_o(data_ready_o), .bit_o(bit_o), .bit_valid_o(bit_valid_o),
      .match_o(match_o), .match_cnt_o(match_cnt_o), .irq_o(irq_o),
      .busy_o(busy_o)
   );

   always #5 clk_c = ~clk_c;

   typedef struct packed {
      logic b;
      logic m;
      logic irq;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   logic       mon_en = 1'b1;
   logic       have_prev = 1'b0;
   exp_t       prev;

   // reference model state
   logic [7:0] m_pat;
   int         m_len;
   logic       m_ovl;
   logic [7:0] m_thr;
   logic [7:0] m_hist;
   int         m_fill;
   int         m_cnt;
   logic       m_irq;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_word(input logic [7:0] w);
      logic [7:0] mask;
      logic       b;
      logic       m;
      for (int i = 7; i >= 0; i--) begin
         b      = w[i];
         m_hist = {m_hist[6:0], b};
         m_fill = (m_fill < 8) ? m_fill + 1 : 8;
         mask   = 8'hFF >> (8 - m_len);
         m      = (m_fill >= m_len) && ((m_hist & mask) == (m_pat & mask));
         if (m) begin
            if (!m_ovl) m_fill = 0;
            if (m_cnt < 255) m_cnt++;
            if (m_thr != 0 && m_cnt == int'(m_thr)) m_irq = 1'b1;
         end
         sb.push_back('{b: b, m: m, irq: m_irq});
      end
   endfunction

   always @(negedge clk_c) begin
      if (mon_en) begin
         if (have_prev) begin
            check("match_o", match_o, prev.m);
            check("irq_o", irq_o, prev.irq);
         end
         if (bit_valid_o) begin
            checks++;
            assert (sb.size() > 0) else begin
               failures++;
               $error("FAIL bit_valid_unexpected observed=1 expected=0");
            end
            if (sb.size() > 0) begin
               prev = sb.pop_front();
               check("bit_o", bit_o, prev.b);
               have_prev = 1'b1;
            end else begin
               have_prev = 1'b0;
            end
         end else begin
            have_prev = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk_c);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!data_ready_o && n < 100) begin
         tick();
         n++;
      end
      check("ready_timeout", data_ready_o, 1);
   endtask

   task automatic start_session(input logic [7:0] pat, input logic [2:0] len,
                                input logic ovl, input logic [7:0] thr);
      cfg_we_i      = 1'b1;
      cfg_pattern_i = pat;
      cfg_len_i     = len;
      cfg_overlap_i = ovl;
      cfg_thresh_i  = thr;
      start_i       = 1'b1;
      tick();
      cfg_we_i = 1'b0;
      start_i  = 1'b0;
      m_pat  = pat;
      m_len  = int'(len) + 1;
      m_ovl  = ovl;
      m_thr  = thr;
      m_hist = '0;
      m_fill = 0;
      m_cnt  = 0;
      m_irq  = 1'b0;
      check("start_busy", busy_o, 1);
      check("start_ready", data_ready_o, 1);
      check("start_cnt_clear", match_cnt_o, 0);
      check("start_irq_clear", irq_o, 0);
   endtask

   task automatic send_word(input logic [7:0] w);
      wait_ready();
      data_valid_i = 1'b1;
      data_i       = w;
      model_word(w);
      tick();
      data_valid_i = 1'b0;
   endtask

   task automatic end_session();
      wait_ready();
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      check("stop_busy", busy_o, 0);
      check("stop_ready", data_ready_o, 0);
      check("match_cnt_o", match_cnt_o, m_cnt);
      check("irq_end", irq_o, m_irq);
   endtask

   initial begin
      // reset state
      reset_r = 1'b1;
      #2 reset_r = 1'b0;
      #2;
      check("rst_ready", data_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_bit_valid", bit_valid_o, 0);
      check("rst_match", match_o, 0);
      check("rst_cnt", match_cnt_o, 0);
      check("rst_irq", irq_o, 0);
      tick();
      #3 reset_r = 1'b1;
      // no data accepted before start
      data_valid_i = 1'b1;
      data_i       = 8'hFF;
      repeat (3) tick();
      check("pre_start_ready", data_ready_o, 0);
      check("pre_start_busy", busy_o, 0);
      data_valid_i = 1'b0;

      // 1011, overlapping: matches after bits 4 and 7
      start_session(8'h0B, 3'd3, 1'b1, 8'd0);
      send_word(8'hB6);
      end_session();
      check("ovl_cnt_2", match_cnt_o, 2);

      // non-overlapping: single match
      start_session(8'h0B, 3'd3, 1'b0, 8'd0);
      send_word(8'hB6);
      end_session();
      check("novl_cnt_1", match_cnt_o, 1);

      // history carries across words
      start_session(8'h0B, 3'd3, 1'b1, 8'd0);
      send_word(8'h01);
      send_word(8'h60);
      end_session();
      check("carry_cnt_1", match_cnt_o, 1);

      // irq at 3rd match, counter saturation
      start_session(8'h01, 3'd0, 1'b1, 8'd3);
      for (int i = 0; i < 32; i++) send_word(8'hFF);
      end_session();
      check("sat_cnt", match_cnt_o, 255);
      check("sat_irq", irq_o, 1);
      repeat (3) tick();
      check("idle_hold_cnt", match_cnt_o, 255);
      check("idle_hold_irq", irq_o, 1);
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      check("irq_clr", irq_o, 0);
      check("irq_clr_cnt_hold", match_cnt_o, 255);

      // stop latched in SHIFT at bit 2: word completes, then IDLE
      start_session(8'h0B, 3'd3, 1'b1, 8'd0);
      send_word(8'hB6);
      tick();
      tick();
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      repeat (5) tick();
      check("shift_stop_busy", busy_o, 0);
      check("shift_stop_ready", data_ready_o, 0);
      check("shift_stop_cnt", match_cnt_o, 2);
      @(negedge clk_c);
      #1;
      check("shift_stop_all_bits", sb.size(), 0);

      // config write ignored in WAIT
      start_session(8'h0B, 3'd3, 1'b1, 8'd0);
      cfg_we_i      = 1'b1;
      cfg_pattern_i = 8'h00;
      cfg_len_i     = 3'd0;
      cfg_overlap_i = 1'b0;
      tick();
      cfg_we_i = 1'b0;
      send_word(8'hB6);
      end_session();
      check("cfg_wait_cnt", match_cnt_o, 2);

      // stop and transfer in the same WAIT cycle: stop wins
      start_session(8'h0B, 3'd3, 1'b1, 8'd0);
      wait_ready();
      data_valid_i = 1'b1;
      data_i       = 8'hB6;
      stop_i       = 1'b1;
      tick();
      data_valid_i = 1'b0;
      stop_i       = 1'b0;
      check("stop_xfer_busy", busy_o, 0);
      check("stop_xfer_bit_valid", bit_valid_o, 0);
      repeat (4) tick();
      check("stop_xfer_cnt", match_cnt_o, 0);

      // asynchronous reset mid-SHIFT
      start_session(8'h0B, 3'd3, 1'b1, 8'd1);
      send_word(8'hB6);
      send_word(8'h01);
      tick();
      tick();
      check("pre_rst_cnt", match_cnt_o, 2);
      check("pre_rst_irq", irq_o, 1);
      check("pre_rst_bit_valid", bit_valid_o, 1);
      mon_en = 1'b0;
      #2 reset_r = 1'b0;
      #1;
      check("mid_rst_bit_valid", bit_valid_o, 0);
      check("mid_rst_bit", bit_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_ready", data_ready_o, 0);
      check("mid_rst_match", match_o, 0);
      check("mid_rst_cnt", match_cnt_o, 0);
      check("mid_rst_irq", irq_o, 0);
      sb.delete();
      tick();
      #3 reset_r = 1'b1;
      tick();
      have_prev = 1'b0;
      mon_en    = 1'b1;
      data_valid_i = 1'b1;
      repeat (3) tick();
      check("post_rst_ready", data_ready_o, 0);
      check("post_rst_busy", busy_o, 0);
      data_valid_i = 1'b0;
      start_session(8'h0B, 3'd3, 1'b1, 8'd0);
      send_word(8'h60);
      send_word(8'hB6);
      end_session();
      check("post_rst_cnt", match_cnt_o, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have parameter PAT_W, default 8, meaning maximum pattern length and input word width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-003 The block SHALL have port clk_c  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_r  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port cfg_we_i  in  1  configuration write strobe.
REQ-006 The block SHALL have port cfg_pattern_i  in  PAT_W  pattern; the last bit received is compared with bit 0.
REQ-007 The block SHALL have port cfg_len_i  in  $clog2(PAT_W)  pattern length minus 1.
REQ-008 The block SHALL have port cfg_overlap_i  in  1  overlap mode: 1 = overlapping matches, 0 = non-overlapping.
REQ-009 The block SHALL have port cfg_thresh_i  in  CNT_W  irq threshold; 0 disables irq.
REQ-010 The block SHALL have ports start_i, stop_i and irq_clr_i  in  1 each  session control strobes.
REQ-011 The block SHALL have ports data_valid_i  in  1, data_i  in  PAT_W and data_ready_o  out  1, forming the word input handshake.
REQ-012 The block SHALL have ports bit_o  out  1 and bit_valid_o  out  1  serialized bit stream.
REQ-013 The block SHALL have ports match_o  out  1, match_cnt_o  out  CNT_W, irq_o  out  1 and busy_o  out  1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and SHIFT; busy_o SHALL be 1 in WAIT and SHIFT.
REQ-015 IDLE: cfg_we_i SHALL latch all cfg_* inputs; cfg_we_i SHALL be ignored in any other state.
REQ-016 IDLE: start_i SHALL move the FSM to WAIT and clear history, fill count, match_cnt_o and irq_o; if cfg_we_i is asserted in the same cycle, the session SHALL use the newly written config; start_i SHALL be ignored outside IDLE.
REQ-017 WAIT: data_ready_o SHALL be 1, and it SHALL be 0 in all other states; a transfer (valid && ready) SHALL capture data_i and move to SHIFT.
REQ-018 SHIFT: the block SHALL emit one bit per cycle, MSB first, for exactly PAT_W cycles with bit_valid_o=1, then return to WAIT; this gives a throughput of PAT_W+1 cycles per word.
REQ-019 Each emitted bit SHALL shift into the history register; history and fill count SHALL persist across words within a session.
REQ-020 A match SHALL occur on a bit when fill count >= len and the low len bits of the updated history equal the low len bits of the pattern, where len = cfg_len+1.
REQ-021 On a match with overlap=0, the fill count SHALL clear; with overlap=1 it SHALL be unaffected; the fill count SHALL saturate at PAT_W.
REQ-022 match_o SHALL be a registered one-cycle pulse in the cycle after the completing bit.
REQ-023 match_cnt_o SHALL increment with match_o and saturate at 2^CNT_W-1.
REQ-024 irq_o SHALL set when thresh!=0 and the updated count == thresh, and SHALL be sticky until irq_clr_i or start_i; if set and irq_clr_i coincide, set SHALL win.
REQ-025 stop_i in WAIT SHALL go to IDLE the next cycle; stop_i in SHIFT SHALL be latched, the current word SHALL finish, and the FSM SHALL then go to IDLE instead of WAIT.
REQ-026 stop_i and a transfer in the same WAIT cycle: the stop SHALL win and the word SHALL NOT be accepted.
REQ-027 match_cnt_o and irq_o SHALL hold their values in IDLE after a session.

Reset
REQ-028 reset_r=0 SHALL immediately force IDLE and set every output, the config registers, history, fill count, bit index and stop latch to 0, including mid-SHIFT.
REQ-029 After deassertion of reset_r, the block SHALL require start_i before accepting data.

Verification
REQ-030 cfg 1011 (pattern 0x0B, len 3), overlap=1, word 0xB6 -> match_o after bits 4 and 7; match_cnt_o=2.
REQ-031 Same config with overlap=0, word 0xB6 -> a single match after bit 4; match_cnt_o=1.
REQ-032 Pattern 1011, words 0x01 then 0x60 -> one match on the 3rd bit of the second word, showing history carries across words.
REQ-033 Pattern 0x01, len 1, thresh 3, 32 words of 0xFF -> irq_o rises with the 3rd match; match_cnt_o ends at 255 (saturated).
REQ-034 stop_i in SHIFT at bit 2 -> all 8 bits are emitted, then IDLE, data_ready_o=0; cfg_we_i in WAIT -> config unchanged.
REQ-035 reset_r low mid-SHIFT -> all outputs are 0 asynchronously; after release and start_i, detection begins with empty history.
